seg_display_scanner: RTL and testbench

Time-multiplexing controller for the four-digit seven-segment display. It holds a 16-bit hex value plus four decimal points and rotates through the digits at a programmable refresh rate. For each digit it drives the 2-bit digit select, the 4-bit nibble and the dot into the existing seven-segment decoder. Value updates go through a load handshake and are committed only at frame boundaries, so a frame never shows a mix of old and new digits. Optional leading-zero blanking and a global enable are included.

---
 rtl/seg_display_pkg.sv | 31 +++
 rtl/refresh_prescaler.sv | 27 ++
 rtl/seg_display_scanner.sv | 105 ++++++++++
 tb/tb_seg_display_scanner.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// Shared constants, the display word type and the leading-zero blanking helper
// for the seven-segment scanner.
package seg_display_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int SEL_W      = 2;
  localparam int VALUE_W    = NUM_DIGITS * DIGIT_W;

  localparam logic DOT_LIT = 1'b0;
  localparam logic DOT_OFF = 1'b1;

  typedef struct packed {
    logic [VALUE_W-1:0]    value;
    logic [NUM_DIGITS-1:0] dots;
  } disp_word_t;

  // Bit i set when digit i and every digit to its left are zero; digit 0 is never blanked.
  function automatic logic [NUM_DIGITS-1:0] lead_zero_mask(input logic [VALUE_W-1:0] value);
    logic [NUM_DIGITS-1:0] mask;
    logic                  all_zero;
    mask     = '0;
    all_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero = all_zero & (value[i*DIGIT_W +: DIGIT_W] == '0);
      mask[i]  = all_zero;
    end
    return mask;
  endfunction

endpackage

// File: rtl/refresh_prescaler.sv
// Free-running divider: counts 0..DIV-1 and flags the terminal count as TICK_OUT.
module refresh_prescaler #(
  parameter int DIV = 100000
) (
  input  logic CLK,
  input  logic RESET,
  output logic TICK_OUT
);

  localparam int            W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0]  LAST = W'(DIV - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    TICK_OUT = (count_q == LAST);
    count_d  = TICK_OUT ? '0 : count_q + W'(1);
  end

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/seg_display_scanner.sv
// Four-digit seven-segment scan controller with frame-aligned value commits,
// leading-zero blanking and a global enable. All outputs are registered.
module seg_display_scanner
  import seg_display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [VALUE_W-1:0]    VALUE_IN,
  input  logic [NUM_DIGITS-1:0] DOTS_IN,
  input  logic                  LOAD_IN,
  output logic                  LOAD_ACK_OUT,
  input  logic                  BLANK_LEAD_IN,
  input  logic                  ENABLE_IN,
  output logic [SEL_W-1:0]      SEG_SELECT_OUT,
  output logic [DIGIT_W-1:0]    BIN_OUT,
  output logic                  DOT_OUT,
  output logic                  BLANK_OUT
);

  localparam logic [SEL_W-1:0] LAST_INDEX = SEL_W'(NUM_DIGITS - 1);

  logic tick;
  logic boundary;
  logic commit;

  logic [SEL_W-1:0]      index_q, index_d;
  disp_word_t            staging_q, staging_d;
  disp_word_t            displayed_q, displayed_d;
  logic                  pending_q, pending_d;
  logic                  ack_q, ack_d;
  logic [SEL_W-1:0]      sel_q, sel_d;
  logic [DIGIT_W-1:0]    bin_q, bin_d;
  logic                  dot_q, dot_d;
  logic                  blank_q, blank_d;
  logic [NUM_DIGITS-1:0] lead_mask;

  refresh_prescaler #(
    .DIV(REFRESH_DIV)
  ) u_prescaler (
    .CLK     (CLK),
    .RESET   (RESET),
    .TICK_OUT(tick)
  );

  // NOTE: every signal gets a default at the top of always_comb so no latch is inferred.
  always_comb begin
    boundary    = tick && (index_q == LAST_INDEX);
    commit      = boundary && pending_q;
    index_d     = tick ? index_q + SEL_W'(1) : index_q;
    staging_d   = staging_q;
    displayed_d = displayed_q;
    pending_d   = pending_q;
    ack_d       = commit;

    // Commit reads the old staging value, so a coincident load is held for the next frame.
    if (commit) begin
      displayed_d = staging_q;
      pending_d   = 1'b0;
    end
    if (LOAD_IN) begin
      staging_d = '{value: VALUE_IN, dots: DOTS_IN};
      pending_d = 1'b1;
    end

    // Outputs follow the next-state index/display so a new frame and its ACK line up.
    lead_mask = lead_zero_mask(displayed_d.value);
    sel_d     = index_d;
    bin_d     = displayed_d.value[index_d*DIGIT_W +: DIGIT_W];
    dot_d     = displayed_d.dots[index_d] ? DOT_LIT : DOT_OFF;
    blank_d   = ~ENABLE_IN | (BLANK_LEAD_IN & lead_mask[index_d]);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      index_q     <= '0;
      staging_q   <= '0;
      displayed_q <= '0;
      pending_q   <= 1'b0;
      ack_q       <= 1'b0;
      sel_q       <= '0;
      bin_q       <= '0;
      dot_q       <= DOT_OFF;
      blank_q     <= 1'b1;
    end else begin
      index_q     <= index_d;
      staging_q   <= staging_d;
      displayed_q <= displayed_d;
      pending_q   <= pending_d;
      ack_q       <= ack_d;
      sel_q       <= sel_d;
      bin_q       <= bin_d;
      dot_q       <= dot_d;
      blank_q     <= blank_d;
    end
  end

  assign LOAD_ACK_OUT   = ack_q;
  assign SEG_SELECT_OUT = sel_q;
  assign BIN_OUT        = bin_q;
  assign DOT_OUT        = dot_q;
  assign BLANK_OUT      = blank_q;

endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner with REFRESH_DIV=4: edges are counted from
// reset release, so slot s spans edges 4s..4s+3 and frame f spans edges 16f..16f+15.
module tb_seg_display_scanner;

  localparam int DIV = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [15:0] VALUE_IN;
  logic [3:0]  DOTS_IN;
  logic        LOAD_IN;
  logic        LOAD_ACK_OUT;
  logic        BLANK_LEAD_IN;
  logic        ENABLE_IN;
  logic [1:0]  SEG_SELECT_OUT;
  logic [3:0]  BIN_OUT;
  logic        DOT_OUT;
  logic        BLANK_OUT;

  int n_tests = 0;
  int n_fail  = 0;
  int edges   = 0;
  int ack_cnt = 0;
  int last_ack_edge = -1;
  int ack_before;

  seg_display_scanner #(
    .REFRESH_DIV(DIV)
  ) dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .VALUE_IN      (VALUE_IN),
    .DOTS_IN       (DOTS_IN),
    .LOAD_IN       (LOAD_IN),
    .LOAD_ACK_OUT  (LOAD_ACK_OUT),
    .BLANK_LEAD_IN (BLANK_LEAD_IN),
    .ENABLE_IN     (ENABLE_IN),
    .SEG_SELECT_OUT(SEG_SELECT_OUT),
    .BIN_OUT       (BIN_OUT),
    .DOT_OUT       (DOT_OUT),
    .BLANK_OUT     (BLANK_OUT)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge, sampled 1 time unit later; ACK pulses are logged here.
  task automatic step();
    @(posedge CLK);
    #1;
    edges++;
    if (LOAD_ACK_OUT === 1'b1) begin
      ack_cnt++;
      last_ack_edge = edges;
    end
  endtask

  task automatic run_to(input int e);
    while (edges < e) step();
  endtask

  // Drives LOAD_IN after edge e so the value is captured on edge e+1.
  task automatic do_load(input int e, input logic [15:0] v, input logic [3:0] d);
    run_to(e);
    VALUE_IN = v;
    DOTS_IN  = d;
    LOAD_IN  = 1'b1;
    step();
    LOAD_IN  = 1'b0;
  endtask

  // Samples the middle of each digit slot of frame f.
  task automatic check_frame(input int f, input logic [15:0] v, input logic [3:0] d,
                             input logic [3:0] blank_mask);
    logic [3:0] nib;
    logic       dot_exp;
    logic       blank_exp;
    for (int i = 0; i < 4; i++) begin
      run_to(16 * f + 4 * i + 2);
      nib       = v[4*i +: 4];
      dot_exp   = d[i] ? 1'b0 : 1'b1;
      blank_exp = blank_mask[i];
      check($sformatf("f%0d_d%0d_sel", f, i), 32'(SEG_SELECT_OUT), i);
      check($sformatf("f%0d_d%0d_bin", f, i), 32'(BIN_OUT), 32'(nib));
      check($sformatf("f%0d_d%0d_dot", f, i), 32'(DOT_OUT), 32'(dot_exp));
      check($sformatf("f%0d_d%0d_blank", f, i), 32'(BLANK_OUT), 32'(blank_exp));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_sel"},   32'(SEG_SELECT_OUT), 0);
    check({tag, "_bin"},   32'(BIN_OUT), 0);
    check({tag, "_dot"},   32'(DOT_OUT), 1);
    check({tag, "_blank"}, 32'(BLANK_OUT), 1);
    check({tag, "_ack"},   32'(LOAD_ACK_OUT), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET         = 1'b1;
    VALUE_IN      = '0;
    DOTS_IN       = '0;
    LOAD_IN       = 1'b0;
    BLANK_LEAD_IN = 1'b0;
    ENABLE_IN     = 1'b1;

    repeat (3) @(posedge CLK);
    #1;
    check_reset_values("reset");
    RESET = 1'b0;
    edges = 0;

    // Scan rotation with nothing loaded.
    check_frame(0, 16'h0000, 4'b0000, 4'b0000);
    run_to(18);
    check("rot_wrap_sel", 32'(SEG_SELECT_OUT), 0);

    // Load at index 1 of frame 1; ACK only at the frame boundary.
    do_load(21, 16'hA5C3, 4'b0100);
    run_to(31);
    check("load_no_early_ack", ack_cnt, 0);
    run_to(32);
    check("load_ack_cnt", ack_cnt, 1);
    check("load_ack_edge", last_ack_edge, 32);
    run_to(33);
    check("load_ack_pulse", 32'(LOAD_ACK_OUT), 0);
    check_frame(2, 16'hA5C3, 4'b0100, 4'b0000);

    // Overwrite within one frame: latest value wins, one ACK.
    do_load(49, 16'h1111, 4'b0000);
    do_load(55, 16'h2222, 4'b0000);
    run_to(64);
    check("ovw_ack_cnt", ack_cnt, 2);
    check("ovw_ack_edge", last_ack_edge, 64);
    check_frame(4, 16'h2222, 4'b0000, 4'b0000);

    // Boundary collision: staged 0001 commits, 0002 captured on the boundary waits a frame.
    do_load(84, 16'h0001, 4'b0000);
    do_load(95, 16'h0002, 4'b0000);
    check("coll_ack1_cnt", ack_cnt, 3);
    check("coll_ack1_edge", last_ack_edge, 96);
    check_frame(6, 16'h0001, 4'b0000, 4'b0000);
    run_to(112);
    check("coll_ack2_cnt", ack_cnt, 4);
    check("coll_ack2_edge", last_ack_edge, 112);
    check_frame(7, 16'h0002, 4'b0000, 4'b0000);

    // Leading-zero blanking, then an all-zero value with a lit dot on digit 3.
    BLANK_LEAD_IN = 1'b1;
    do_load(130, 16'h0070, 4'b0000);
    check_frame(9, 16'h0070, 4'b0000, 4'b1100);
    do_load(161, 16'h0000, 4'b1000);
    check_frame(11, 16'h0000, 4'b1000, 4'b1110);
    check("blank_ack_cnt", ack_cnt, 6);

    // Global enable off darkens every digit.
    ENABLE_IN = 1'b0;
    check_frame(12, 16'h0000, 4'b1000, 4'b1111);
    ENABLE_IN     = 1'b1;
    BLANK_LEAD_IN = 1'b0;

    // Reset while a new value is pending at index 2.
    do_load(209, 16'hBEEF, 4'b0100);
    run_to(224);
    check("pre_rst_ack_cnt", ack_cnt, 7);
    do_load(232, 16'h1234, 4'b1111);
    run_to(234);
    check("pre_rst_sel", 32'(SEG_SELECT_OUT), 2);
    check("pre_rst_bin", 32'(BIN_OUT), 32'h0E);
    check("pre_rst_dot", 32'(DOT_OUT), 0);
    check("pre_rst_blank", 32'(BLANK_OUT), 0);
    #2;
    RESET = 1'b1;
    #1;
    check_reset_values("async_rst");
    ack_before = ack_cnt;
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;
    edges = 0;
    check_frame(0, 16'h0000, 4'b0000, 4'b0000);
    check_frame(1, 16'h0000, 4'b0000, 4'b0000);
    run_to(33);
    check("post_rst_no_ack", ack_cnt, ack_before);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
